// File: rtl/chunk_serializer.sv
// chunk_serializer: accepts one INWIDTH-bit word over a valid/ready handshake and
// emits it as a sequence of OUTWIDTH-bit chunks over a second valid/ready handshake.
//
// Parameters:
//   INWIDTH   input word width (integer multiple of OUTWIDTH)
//   OUTWIDTH  output chunk width
//   MSB_FIRST 1 = most-significant chunk first, 0 = least-significant chunk first
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_data_i    word to serialise
//   in_len_i     chunk count; 0 or > NCHUNK means NCHUNK
//   in_valid_i   producer offers in_data_i/in_len_i
//   in_ready_o   block can accept a word this cycle
//   out_data_o   current chunk
//   out_valid_o  out_data_o is valid
//   out_ready_i  consumer accepts out_data_o this cycle
//   out_last_o   current chunk is the final chunk of the word
//   busy_o       a word is being emitted
//
// Build option CHUNK_SERIALIZER_PREFETCH_EN adds a one-entry holding register so the
// next word can be accepted while the current one is emitted (zero-bubble throughput).
module chunk_serializer #(
  parameter int unsigned INWIDTH   = 32,
  parameter int unsigned OUTWIDTH  = 8,
  parameter int unsigned MSB_FIRST = 1,
  localparam int unsigned NCHUNK   = INWIDTH / OUTWIDTH,
  localparam int unsigned LW       = $clog2(NCHUNK + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INWIDTH-1:0]  in_data_i,
  input  logic [LW-1:0]       in_len_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [OUTWIDTH-1:0] out_data_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                out_last_o,
  output logic                busy_o
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e             state_q;
  logic [INWIDTH-1:0] shift_q;
  logic [LW-1:0]      rem_q;

  logic [LW-1:0]      eff_len;
  logic [INWIDTH-1:0] shift_next;
  logic               in_fire;
  logic               out_fire;

  // Zero or out-of-range lengths mean a full word.
  assign eff_len = ((in_len_i == '0) || (in_len_i > LW'(NCHUNK))) ? LW'(NCHUNK) : in_len_i;

  // Shift toward the output end, zero-filling the vacated chunk.
  assign shift_next = (MSB_FIRST != 0) ? (shift_q << OUTWIDTH) : (shift_q >> OUTWIDTH);

  assign out_data_o  = (MSB_FIRST != 0) ? shift_q[INWIDTH-1 -: OUTWIDTH]
                                        : shift_q[OUTWIDTH-1:0];
  assign out_valid_o = (state_q == StShift);
  assign busy_o      = (state_q == StShift);
  assign out_last_o  = (state_q == StShift) && (rem_q == LW'(1));
  assign out_fire    = out_valid_o && out_ready_i;
  assign in_fire     = in_valid_i && in_ready_o;

`ifdef CHUNK_SERIALIZER_PREFETCH_EN
  logic [INWIDTH-1:0] hold_data_q;
  logic [LW-1:0]      hold_len_q;
  logic               hold_full_q;

  // Driven from a register only, so it never depends on out_ready_i.
  assign in_ready_o = !hold_full_q;
`else
  assign in_ready_o = (state_q == StIdle);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      rem_q       <= '0;
`ifdef CHUNK_SERIALIZER_PREFETCH_EN
      hold_data_q <= '0;
      hold_len_q  <= '0;
      hold_full_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_fire) begin
            shift_q <= in_data_i;
            rem_q   <= eff_len;
            state_q <= StShift;
          end
        end
        StShift: begin
`ifdef CHUNK_SERIALIZER_PREFETCH_EN
          // Park a word accepted mid-emission unless it is consumed directly below.
          if (in_fire && !(out_fire && out_last_o)) begin
            hold_data_q <= in_data_i;
            hold_len_q  <= eff_len;
            hold_full_q <= 1'b1;
          end
`endif
          if (out_fire) begin
            if (out_last_o) begin
`ifdef CHUNK_SERIALIZER_PREFETCH_EN
              if (hold_full_q) begin
                shift_q     <= hold_data_q;
                rem_q       <= hold_len_q;
                hold_full_q <= 1'b0;
              end else if (in_fire) begin
                // Holding register empty: the arriving word goes straight to the shifter.
                shift_q <= in_data_i;
                rem_q   <= eff_len;
              end else begin
                shift_q <= '0;
                rem_q   <= '0;
                state_q <= StIdle;
              end
`else
              // Unsent chunks of a short word are discarded here.
              shift_q <= '0;
              rem_q   <= '0;
              state_q <= StIdle;
`endif
            end else begin
              shift_q <= shift_next;
              rem_q   <= rem_q - LW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_serializer.sv
module tb_chunk_serializer;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [2:0]  in_len;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready_m, out_valid_m, out_last_m, busy_m;
  logic [7:0]  out_data_m;
  logic        in_ready_l, out_valid_l, out_last_l, busy_l;
  logic [7:0]  out_data_l;

  int n_cmp = 0;
  int n_err = 0;

  chunk_serializer #(.INWIDTH(32), .OUTWIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data_i  (in_data),
    .in_len_i   (in_len),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready_m),
    .out_data_o (out_data_m),
    .out_valid_o(out_valid_m),
    .out_ready_i(out_ready),
    .out_last_o (out_last_m),
    .busy_o     (busy_m)
  );

  chunk_serializer #(.INWIDTH(32), .OUTWIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data_i  (in_data),
    .in_len_i   (in_len),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready_l),
    .out_data_o (out_data_l),
    .out_valid_o(out_valid_l),
    .out_ready_i(out_ready),
    .out_last_o (out_last_l),
    .busy_o     (busy_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one word, then drive out_ready from rdy_pat (bit k = cycle k after accept)
  // and check every cycle against the expected chunk sequences, read top byte first.
  task automatic send_word(input string tag, input logic [31:0] d, input logic [2:0] len,
                           input logic [15:0] rdy_pat, input int n_exp,
                           input logic [31:0] seq_m, input logic [31:0] seq_l);
    int got;
    int k;
    logic [7:0] exp_m;
    logic [7:0] exp_l;
    in_data  = d;
    in_len   = len;
    in_valid = 1'b1;
    @(negedge clk);
    check_eq({tag, " accept_ready"}, {31'b0, in_ready_m}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    got = 0;
    k   = 0;
    while (got < n_exp && k < 40) begin
      out_ready = (k < 16) ? rdy_pat[k] : 1'b1;
      @(negedge clk);
      exp_m = seq_m[31 - 8*got -: 8];
      exp_l = seq_l[31 - 8*got -: 8];
      check_eq({tag, " valid"}, {31'b0, out_valid_m}, 32'd1);
      check_eq({tag, " busy"}, {31'b0, busy_m}, 32'd1);
`ifndef CHUNK_SERIALIZER_PREFETCH_EN
      check_eq({tag, " in_ready_shift"}, {31'b0, in_ready_m}, 32'd0);
`endif
      check_eq({tag, " data_msb"}, {24'b0, out_data_m}, {24'b0, exp_m});
      check_eq({tag, " data_lsb"}, {24'b0, out_data_l}, {24'b0, exp_l});
      check_eq({tag, " last"}, {31'b0, out_last_m}, {31'b0, got == n_exp - 1});
      check_eq({tag, " last_lsb"}, {31'b0, out_last_l}, {31'b0, got == n_exp - 1});
      if (out_valid_m && out_ready) got++;
      @(posedge clk);
      #1;
      k++;
    end
    check_eq({tag, " timeout"}, {31'b0, k < 40}, 32'd1);
    @(negedge clk);
    check_eq({tag, " idle_valid"}, {31'b0, out_valid_m}, 32'd0);
    check_eq({tag, " idle_ready"}, {31'b0, in_ready_m}, 32'd1);
    check_eq({tag, " idle_busy"}, {31'b0, busy_m}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] fire_data [8];
  int         fire_cyc  [8];
  int         n_fire;
  logic [63:0] b2b_seq;

  initial begin
    rst_n     = 1'b1;
    in_data   = '0;
    in_len    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2 rst_n  = 1'b0;
    #2;
    check_eq("rst in_ready", {31'b0, in_ready_m}, 32'd1);
    check_eq("rst out_valid", {31'b0, out_valid_m}, 32'd0);
    check_eq("rst out_last", {31'b0, out_last_m}, 32'd0);
    check_eq("rst busy", {31'b0, busy_m}, 32'd0);
    check_eq("rst out_data", {24'b0, out_data_m}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_word("full_len0", 32'hA1B2C3D4, 3'd0, 16'hFFFF, 4, 32'hA1B2C3D4, 32'hD4C3B2A1);
    send_word("len2", 32'hA1B2C3D4, 3'd2, 16'hFFFF, 2, 32'hA1B2C3D4, 32'hD4C3B2A1);
    send_word("len7", 32'hA1B2C3D4, 3'd7, 16'hFFFF, 4, 32'hA1B2C3D4, 32'hD4C3B2A1);
    send_word("len1", 32'hA1B2C3D4, 3'd1, 16'hFFFF, 1, 32'hA1B2C3D4, 32'hD4C3B2A1);
    send_word("bp", 32'hA1B2C3D4, 3'd4, 16'hFF69, 4, 32'hA1B2C3D4, 32'hD4C3B2A1);

    // Reset mid-word after two chunks have been accepted.
    in_data   = 32'hA1B2C3D4;
    in_len    = 3'd0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst out_valid", {31'b0, out_valid_m}, 32'd0);
    check_eq("midrst in_ready", {31'b0, in_ready_m}, 32'd1);
    check_eq("midrst busy", {31'b0, busy_m}, 32'd0);
    check_eq("midrst out_last", {31'b0, out_last_m}, 32'd0);
    check_eq("midrst out_data", {24'b0, out_data_m}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_word("after_rst", 32'h11223344, 3'd0, 16'hFFFF, 4, 32'h11223344, 32'h44332211);

    // Two words back to back with the consumer always ready.
    b2b_seq   = 64'hA1B2C3D455667788;
    n_fire    = 0;
    out_ready = 1'b1;
    in_data   = 32'hA1B2C3D4;
    in_len    = 3'd0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_data  = 32'h55667788;
    in_valid = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      logic take;
      @(negedge clk);
      take = in_valid && in_ready_m;
      if (out_valid_m && out_ready && n_fire < 8) begin
        fire_data[n_fire] = out_data_m;
        fire_cyc[n_fire]  = t;
        n_fire++;
      end
      @(posedge clk);
      #1;
      if (take) in_valid = 1'b0;
    end
    check_eq("b2b count", n_fire, 32'd8);
    for (int i = 0; i < n_fire; i++) begin
      check_eq("b2b data", {24'b0, fire_data[i]}, {24'b0, b2b_seq[63 - 8*i -: 8]});
`ifdef CHUNK_SERIALIZER_PREFETCH_EN
      check_eq("b2b cycle", fire_cyc[i], i + 1);
`else
      check_eq("b2b cycle", fire_cyc[i], (i < 4) ? i + 1 : i + 2);
`endif
    end
    check_eq("b2b end_valid", {31'b0, out_valid_m}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/chunk_serializer.md
Name: chunk_serializer

Overview:
- Parametrised successor to the single-register shift-out primitive. Accepts one INWIDTH-bit word over a valid/ready handshake and emits it as a sequence of OUTWIDTH-bit chunks over a second valid/ready handshake.
- Adds programmable chunk count, selectable shift order, last-chunk flagging and backpressure.
- Sits between the packet framer and the byte-level PHY transmit path of the networking layer.

Parameters:
- INWIDTH, 32, input word width; must be an integer multiple of OUTWIDTH.
- OUTWIDTH, 8, output chunk width.
- MSB_FIRST, 1, 1 = most-significant chunk first; 0 = least-significant chunk first.
- Derived, not overridable: NCHUNK = INWIDTH/OUTWIDTH; LW = $clog2(NCHUNK+1).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_data  input  INWIDTH  word to serialise.
- in_len  input  LW  number of chunks to send; 0 or >NCHUNK means NCHUNK.
- in_valid  input  1  producer offers in_data/in_len.
- in_ready  output  1  block can accept a word this cycle.
- out_data  output  OUTWIDTH  current chunk.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_last  output  1  current chunk is the final chunk of the word.
- busy  output  1  a word is being emitted (state SHIFT).

Behaviour:
- Reset (asynchronous): state IDLE; shift register, chunk counter and out_data = 0; out_valid = 0; out_last = 0; busy = 0; in_ready = 1.
- States: IDLE and SHIFT.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready: latch in_data into the shift register and latch the effective length (in_len clamped per Ports) into the remaining counter; next state SHIFT.
- SHIFT:
  - out_valid = 1, busy = 1.
  - out_data = shift register bits [INWIDTH-1 : INWIDTH-OUTWIDTH] if MSB_FIRST, else [OUTWIDTH-1 : 0].
  - out_last = (remaining == 1).
  - On out_valid & out_ready: shift by OUTWIDTH toward the output end, zero-filling; decrement remaining. If out_last, next state IDLE (or reload; see Optional Feature).
- Latency: first chunk is valid the cycle after the input handshake.
- Backpressure: while out_valid & !out_ready, out_data, out_last and remaining hold stable. Chunks are never dropped or duplicated.
- Without the Optional Feature, in_ready = 0 throughout SHIFT. This gives one bubble cycle per word: last chunk accepted, then IDLE, then accept, then SHIFT.
- in_ready never depends combinationally on out_ready. out_valid never depends combinationally on in_valid.
- in_len = 1: single chunk with out_last asserted immediately.
- Unsent chunks beyond the effective length are discarded when returning to IDLE.
- Reset asserted mid-word: emission aborts immediately; all outputs take reset values; the partial word is lost.
- Bits of in_data beyond the effective length are don't-care.

Optional Feature:
- Macro: CHUNK_SERIALIZER_PREFETCH_EN.
- Defined:
  - Adds a one-entry holding register (data + length) with a full flag; in_ready = !hold_full in both states.
  - A word accepted in SHIFT goes to the holding register.
  - When the last chunk is accepted and hold_full = 1: reload the shift register and counter from the holding register in the same edge, clear hold_full, remain in SHIFT. Result: zero-bubble, 100% throughput.
  - When a word is accepted in IDLE, it loads the shift register directly.
  - Simultaneous holding-register drain and new in_valid is not possible, since in_ready = 0 while hold_full = 1.
  - Reset clears hold_full.
- Undefined: no holding register; behaviour exactly as described in Behaviour.

Test Plan:
- Defaults, in_data = 32'hA1B2C3D4, in_len = 0, out_ready = 1 -> out_data A1, B2, C3, D4 on 4 consecutive cycles starting 1 cycle after accept; out_last only with D4; in_ready = 0 during SHIFT; busy = 1 for 4 cycles.
- Same word, in_len = 2 -> A1, B2 only, out_last with B2; back to IDLE (in_ready = 1) next cycle. in_len = 7 -> behaves as 4.
- out_ready pattern 1,0,0,1,0,1,1 -> each chunk held stable while out_ready = 0; exactly A1, B2, C3, D4 delivered in order; no extra out_valid after D4.
- MSB_FIRST = 0, same word -> D4, C3, B2, A1, with out_last on A1.
- Reset pulsed after 2 chunks accepted -> out_valid = 0 and in_ready = 1 immediately. New word 32'h11223344 then emits 11, 22, 33, 44 with no residue.
- Two words back-to-back (A1B2C3D4, 55667788), out_ready = 1:
  - Macro defined -> 8 consecutive valid chunks, no gap.
  - Macro undefined -> exactly 1 idle cycle between D4 and 55.
